// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep unit: reduction-function select
// codes and the sweep controller state type.
package gate_sweep_pkg;

   localparam logic [1:0] MODE_OR  = 2'b00;
   localparam logic [1:0] MODE_AND = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_NOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/gate_sweep_unit_reduce.sv
// Combinational WIDTH-input reduction gate with a selectable function
// (OR, AND, XOR, NOR).
module reduce_gate
   import gate_sweep_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] in_vec,
   input  logic [1:0]       mode,
   output logic             out
);

   always_comb begin
      out = 1'b0;
      case (mode)
         MODE_OR:  out = |in_vec;
         MODE_AND: out = &in_vec;
         MODE_XOR: out = ^in_vec;
         MODE_NOR: out = ~(|in_vec);
         default:  out = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_sweep_unit.sv
// Self-running exhaustive sweep of a WIDTH-input reduction gate: steps every
// input pattern, holds each for HOLD cycles and tallies patterns giving 1.
module gate_sweep_unit
   import gate_sweep_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int HOLD  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] pattern,
   output logic             result,
   output logic             valid,
   output logic [WIDTH:0]   hit_count,
   output logic             busy,
   output logic             done
);

   localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
   localparam logic [WIDTH-1:0]  PAT_LAST  = '1;

   state_t            state_q, state_d;
   logic [1:0]        mode_q, mode_d;
   logic [WIDTH-1:0]  pattern_q, pattern_d;
   logic              result_q, result_d;
   logic              valid_q, valid_d;
   logic [WIDTH:0]    hit_q, hit_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              load_vec;
   logic              gate_out;

   // Evaluated on the next pattern/mode so result always matches pattern.
   reduce_gate #(
      .WIDTH (WIDTH)
   ) u_reduce (
      .in_vec (pattern_d),
      .mode   (mode_d),
      .out    (gate_out)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      pattern_d = pattern_q;
      hold_d    = hold_q;
      hit_d     = hit_q;
      valid_d   = 1'b0;
      load_vec  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d   = RUN;
               mode_d    = mode;
               pattern_d = '0;
               hold_d    = '0;
               hit_d     = '0;
               load_vec  = 1'b1;
               valid_d   = (HOLD == 1);
            end
         end
         RUN: begin
            if (valid_q && result_q) begin
               hit_d = hit_q + 1'b1;
            end
            if (hold_q == HOLD_LAST) begin
               hold_d = '0;
               if (pattern_q == PAT_LAST) begin
                  state_d = DONE;
               end else begin
                  pattern_d = pattern_q + 1'b1;
                  load_vec  = 1'b1;
                  valid_d   = (HOLD == 1);
               end
            end else begin
               hold_d  = hold_q + 1'b1;
               valid_d = (hold_d == HOLD_LAST);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      result_d = result_q;
      if (load_vec) begin
         result_d = gate_out;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mode_q    <= MODE_OR;
         pattern_q <= '0;
         result_q  <= 1'b0;
         valid_q   <= 1'b0;
         hit_q     <= '0;
         hold_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         pattern_q <= pattern_d;
         result_q  <= result_d;
         valid_q   <= valid_d;
         hit_q     <= hit_d;
         hold_q    <= hold_d;
      end
   end

   assign pattern   = pattern_q;
   assign result    = result_q;
   assign valid     = valid_q;
   assign hit_count = hit_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule
